pc_sequencer: RTL and testbench

- Fetch-side controller for the 16-bit program counter register.
- Each cycle it decides whether the PC loads, and what value it loads: reset vector, sequential increment, or branch/jump redirect.
- Its next_inst_addr and pc_en outputs drive the PC's next-address and enable inputs. The PC's current value feeds back on pc_value.
- It issues fetch requests to instruction memory and flushes the pipeline front end on redirects.

---
 rtl/pc_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-side program counter sequencer
//
// Purpose: decides each cycle whether the external PC register loads, and
// with what: reset vector, sequential increment, or a branch/jump redirect.
// Also raises fetch requests and a one-cycle front-end flush on redirects.
//
// Optional feature macro: PC_SEQ_RAS_EN (call/ret with return-address stack).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   pc_value           current PC register value (feedback)
//   fetch_ack          memory returned the word at pc_value this cycle
//   stall              downstream hazard, hold the PC
//   branch_taken/_target, jump/jump_target   redirect requests
//   call, ret, ras_err (PC_SEQ_RAS_EN only) stack redirects and empty-pop error
//   next_inst_addr     value the PC loads when pc_en=1
//   pc_en              PC load enable
//   fetch_req          request instruction at pc_value
//   flush              one-cycle front-end flush on redirect
//   state              current FSM state (debug)
module pc_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                INC          = 1,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  input  logic              fetch_ack,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
`ifdef PC_SEQ_RAS_EN
  input  logic              call,
  input  logic              ret,
  output logic              ras_err,
`endif
  output logic [ADDR_W-1:0] next_inst_addr,
  output logic              pc_en,
  output logic              fetch_req,
  output logic              flush,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic              redir_req;
  logic [ADDR_W-1:0] redir_addr;
  logic              redir_take;
  logic [ADDR_W-1:0] seq_addr;

  assign state    = cur_state;
  assign seq_addr = pc_value + ADDR_W'(INC);

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_wr_ptr;   // next slot to write; top entry sits just below
  logic [PTR_W-1:0]  ras_top_idx;
  logic [PTR_W-1:0]  ras_wr_inc;
  logic [CNT_W-1:0]  ras_cnt;
  logic              push_req;
  logic              pop_req;
  logic              err_req;
  logic              ras_push;
  logic              ras_pop;

  assign ras_top_idx = (ras_wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wr_ptr - 1'b1;
  assign ras_wr_inc  = (ras_wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wr_ptr + 1'b1;
  assign ras_push    = redir_take & push_req;
  assign ras_pop     = redir_take & pop_req;
  assign ras_err     = redir_take & err_req;
`endif

  // Redirect selection: ret > call > jump > branch_taken.
  always_comb begin
    redir_req  = 1'b0;
    redir_addr = jump_target;
`ifdef PC_SEQ_RAS_EN
    push_req   = 1'b0;
    pop_req    = 1'b0;
    err_req    = 1'b0;
    if (ret) begin
      redir_req = 1'b1;
      if (ras_cnt != '0) begin
        redir_addr = ras_mem[ras_top_idx];
        pop_req    = 1'b1;
      end else begin
        redir_addr = RESET_VECTOR;
        err_req    = 1'b1;
      end
    end else if (call) begin
      redir_req  = 1'b1;
      redir_addr = jump_target;
      push_req   = 1'b1;
    end else
`endif
    if (jump) begin
      redir_req  = 1'b1;
      redir_addr = jump_target;
    end else if (branch_taken) begin
      redir_req  = 1'b1;
      redir_addr = branch_target;
    end
  end

  // Next state and PC control. Outputs are combinational so the PC loads on
  // the same edge the FSM moves.
  always_comb begin
    nxt_state      = cur_state;
    pc_en          = 1'b0;
    fetch_req      = 1'b0;
    flush          = 1'b0;
    next_inst_addr = pc_value;
    redir_take     = 1'b0;
    if (reset) begin
      nxt_state      = BOOT;
      next_inst_addr = RESET_VECTOR;
    end else if (cur_state == BOOT) begin
      pc_en          = 1'b1;
      next_inst_addr = RESET_VECTOR;
      nxt_state      = FETCH;
    end else if (redir_req) begin
      // Redirect wins over stall and fetch_ack; no fetch on the wrong path.
      redir_take     = 1'b1;
      pc_en          = 1'b1;
      flush          = 1'b1;
      next_inst_addr = redir_addr;
      nxt_state      = FLUSH;
    end else begin
      case (cur_state)
        FETCH: begin
          fetch_req = 1'b1;
          if (stall) begin
            nxt_state = HOLD;
          end else if (fetch_ack) begin
            pc_en          = 1'b1;
            next_inst_addr = seq_addr;
          end
        end
        HOLD: begin
          if (!stall) nxt_state = FETCH;
        end
        FLUSH: begin
          nxt_state = FETCH;
        end
        default: begin
          nxt_state = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= BOOT;
    else       cur_state <= nxt_state;
  end

`ifdef PC_SEQ_RAS_EN
  // Circular stack: a push when full overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_wr_ptr <= '0;
      ras_cnt    <= '0;
    end else if (ras_pop) begin
      ras_wr_ptr <= ras_top_idx;
      ras_cnt    <= ras_cnt - 1'b1;
    end else if (ras_push) begin
      ras_mem[ras_wr_ptr] <= seq_addr;
      ras_wr_ptr          <= ras_wr_inc;
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_value = 16'hBEEF;
  logic        fetch_ack = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        jump = 1'b0;
  logic [15:0] jump_target = 16'h0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        ras_err;
  logic [15:0] next_inst_addr;
  logic        pc_en;
  logic        fetch_req;
  logic        flush;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic        en;
    logic        req;
    logic        fl;
    logic        err;
    logic [15:0] nia;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_value      (pc_value),
    .fetch_ack     (fetch_ack),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
`ifdef PC_SEQ_RAS_EN
    .call          (call),
    .ret           (ret),
    .ras_err       (ras_err),
`endif
    .next_inst_addr(next_inst_addr),
    .pc_en         (pc_en),
    .fetch_req     (fetch_req),
    .flush         (flush),
    .state         (state)
  );

`ifndef PC_SEQ_RAS_EN
  assign ras_err = 1'b0;
`endif

  always #5 clk = ~clk;

  // The PC register the sequencer controls.
  always @(posedge clk) if (pc_en) pc_value <= next_inst_addr;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "state", {14'd0, state}, {14'd0, e.st});
      chk(e.name, "pc_en", {15'd0, pc_en}, {15'd0, e.en});
      if (e.req !== 1'bx) chk(e.name, "fetch_req", {15'd0, fetch_req}, {15'd0, e.req});
      chk(e.name, "flush", {15'd0, flush}, {15'd0, e.fl});
      chk(e.name, "next_inst_addr", next_inst_addr, e.nia);
      chk(e.name, "pc_value", pc_value, e.pc);
`ifdef PC_SEQ_RAS_EN
      chk(e.name, "ras_err", {15'd0, ras_err}, {15'd0, e.err});
`endif
    end
  end

  // One cycle: drive inputs just after the edge and queue the expected outputs.
  task automatic cyc(input string nm,
                     input logic r, input logic ack, input logic stl,
                     input logic bt, input logic [15:0] btg,
                     input logic jp, input logic [15:0] jtg,
                     input logic cl, input logic rt,
                     input logic [1:0] est, input logic een, input logic ereq,
                     input logic efl, input logic eerr,
                     input logic [15:0] enia, input logic [15:0] epc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; fetch_ack = ack; stall = stl;
    branch_taken = bt; branch_target = btg;
    jump = jp; jump_target = jtg;
    call = cl; ret = rt;
    e.name = nm; e.st = est; e.en = een; e.req = ereq; e.fl = efl;
    e.err = eerr; e.nia = enia; e.pc = epc;
    exp_q.push_back(e);
  endtask

  initial begin
    //   name        rst ack stl bt btg      jp jtg      cl rt  st   en req   fl err nia      pc
    cyc("rst1",       1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd0, 0, 0,    0, 0, 16'h0000, 16'hBEEF);
    cyc("rst2",       1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd0, 0, 0,    0, 0, 16'h0000, 16'hBEEF);
    cyc("boot",       0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd0, 1, 0,    0, 0, 16'h0000, 16'hBEEF);
    cyc("seq0",       0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 1, 1,    0, 0, 16'h0001, 16'h0000);
    cyc("seq1",       0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 1, 1,    0, 0, 16'h0002, 16'h0001);
    cyc("seq2",       0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 1, 1,    0, 0, 16'h0003, 16'h0002);
    cyc("jmp10",      0, 1, 0, 0, 16'h0000, 1, 16'h0010, 0, 0, 2'd1, 1, 1'bx, 1, 0, 16'h0010, 16'h0003);
    cyc("bub10",      0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0010, 16'h0010);
    cyc("stall_f",    0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 0, 1,    0, 0, 16'h0010, 16'h0010);
    cyc("hold1",      0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd2, 0, 0,    0, 0, 16'h0010, 16'h0010);
    cyc("hold2",      0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd2, 0, 0,    0, 0, 16'h0010, 16'h0010);
    cyc("unstall",    0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd2, 0, 0,    0, 0, 16'h0010, 16'h0010);
    cyc("seq11",      0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 1, 1,    0, 0, 16'h0011, 16'h0010);
    cyc("jmp_vs_br",  0, 1, 0, 1, 16'h0123, 1, 16'h0456, 0, 0, 2'd1, 1, 1'bx, 1, 0, 16'h0456, 16'h0011);
    cyc("bub456",     0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0456, 16'h0456);
    cyc("seq457",     0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 1, 1,    0, 0, 16'h0457, 16'h0456);
    cyc("stall457",   0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 0, 1,    0, 0, 16'h0457, 16'h0457);
    cyc("br_in_hold", 0, 0, 1, 1, 16'h0200, 0, 16'h0000, 0, 0, 2'd2, 1, 1'bx, 1, 0, 16'h0200, 16'h0457);
    cyc("bub200",     0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0200, 16'h0200);
    cyc("noack",      0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 0, 1,    0, 0, 16'h0200, 16'h0200);
    cyc("jmpffff",    0, 1, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 2'd1, 1, 1'bx, 1, 0, 16'hFFFF, 16'h0200);
    cyc("bubffff",    0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'hFFFF, 16'hFFFF);
    cyc("wrap",       0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 1, 1,    0, 0, 16'h0000, 16'hFFFF);
    cyc("br300",      0, 1, 0, 1, 16'h0300, 0, 16'h0000, 0, 0, 2'd1, 1, 1'bx, 1, 0, 16'h0300, 16'h0000);
    cyc("rst_flush",  1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0000, 16'h0300);
    cyc("reboot",     0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd0, 1, 0,    0, 0, 16'h0000, 16'h0300);
    cyc("fetch0",     0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd1, 0, 1,    0, 0, 16'h0000, 16'h0000);
`ifdef PC_SEQ_RAS_EN
    cyc("r_jmp10",    0, 0, 0, 0, 16'h0000, 1, 16'h0010, 0, 0, 2'd1, 1, 1'bx, 1, 0, 16'h0010, 16'h0000);
    cyc("r_bub10",    0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0010, 16'h0010);
    cyc("call100",    0, 0, 0, 0, 16'h0000, 0, 16'h0100, 1, 0, 2'd1, 1, 1'bx, 1, 0, 16'h0100, 16'h0010);
    cyc("bub100",     0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0100, 16'h0100);
    cyc("ret11",      0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 2'd1, 1, 1'bx, 1, 0, 16'h0011, 16'h0100);
    cyc("bub11",      0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0011, 16'h0011);
    cyc("ret_empty",  0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 2'd1, 1, 1'bx, 1, 1, 16'h0000, 16'h0011);
    cyc("bub_err",    0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 2'd3, 0, 0,    0, 0, 16'h0000, 16'h0000);
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
